// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the cache-line memory initiator.
// Line width helper keeps flat line vectors consistent across files.
package mem_if_pkg;

  localparam int AWIDTH_DEF     = 9;
  localparam int DWIDTH_DEF     = 32;
  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int line_bits(
    input int words,
    input int dw
  );
    return words * dw;
  endfunction

endpackage

// File: rtl/mem_line_initiator_if.sv
// Strobe-style main-memory bus between the line initiator and memory.
// Master drives strobes/address/write data; slave returns data and ready.
interface mem_line_initiator_if
  import mem_if_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
);

  logic              rd_mem;
  logic              wr_mem;
  logic [AWIDTH-1:0] addr_mem;
  logic [DWIDTH-1:0] mem_data_in;
  logic [DWIDTH-1:0] mem_data_out;
  logic              ready_mem;

  modport master (
    output rd_mem,
    output wr_mem,
    output addr_mem,
    output mem_data_in,
    input  mem_data_out,
    input  ready_mem
  );

  modport slave (
    input  rd_mem,
    input  wr_mem,
    input  addr_mem,
    input  mem_data_in,
    output mem_data_out,
    output ready_mem
  );

endinterface

// File: rtl/mem_line_buf.sv
// Line buffer: LINE_WORDS x DWIDTH registers with parallel load,
// single-word write at an index and flat parallel read.
module mem_line_buf #(
  parameter int DWIDTH     = 32,
  parameter int LINE_WORDS = 4,
  localparam int OFFW      = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [LINE_WORDS*DWIDTH-1:0] load_line,
  input  logic                         wr_en,
  input  logic [OFFW-1:0]              wr_idx,
  input  logic [DWIDTH-1:0]            wr_data,
  output logic [LINE_WORDS*DWIDTH-1:0] line
);

  logic [DWIDTH-1:0] words [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LINE_WORDS; k++)
        words[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < LINE_WORDS; k++)
        words[k] <= load_line[k*DWIDTH +: DWIDTH];
    end else if (wr_en) begin
      words[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_rd
    assign line[g*DWIDTH +: DWIDTH] = words[g];
  end

endmodule

// File: rtl/mem_line_initiator.sv
// Cache-line initiator: splits a line fill or write-back into
// single-word strobe accesses, one ACCESS/GAP pair per word.
module mem_line_initiator
  import mem_if_pkg::*;
#(
  parameter int AWIDTH     = AWIDTH_DEF,
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  localparam int OFFW      = $clog2(LINE_WORDS),
  localparam int LBITS     = line_bits(LINE_WORDS, DWIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [AWIDTH-OFFW-1:0] req_line_addr,
  input  logic [LBITS-1:0]       req_wdata,
  output logic                   resp_valid,
  output logic [LBITS-1:0]       resp_rdata,
  mem_line_initiator_if.master   mem
);

  localparam logic [OFFW-1:0] LAST = OFFW'(LINE_WORDS - 1);

  state_e                 state;
  logic [OFFW-1:0]        cnt;
  logic [OFFW-1:0]        cnt_nxt;
  logic                   wr_q;
  logic [AWIDTH-OFFW-1:0] line_q;
  logic [LBITS-1:0]       line;
  logic [DWIDTH-1:0]      nxt_word;
  logic                   accept;
  logic                   buf_wr;

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = (state == IDLE) && req_valid;
  assign buf_wr     = (state == ACCESS) && !wr_q;
  assign cnt_nxt    = cnt + OFFW'(1);
  assign nxt_word   = line[int'(cnt_nxt)*DWIDTH +: DWIDTH];
  assign resp_rdata = line;

  // Read data is captured at the edge ending ACCESS
  mem_line_buf #(
    .DWIDTH     (DWIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_line (req_wdata),
    .wr_en     (buf_wr),
    .wr_idx    (cnt),
    .wr_data   (mem.mem_data_out),
    .line      (line)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      wr_q            <= 1'b0;
      line_q          <= '0;
      resp_valid      <= 1'b0;
      mem.rd_mem      <= 1'b0;
      mem.wr_mem      <= 1'b0;
      mem.addr_mem    <= '0;
      mem.mem_data_in <= '0;
    end else begin
      mem.rd_mem <= 1'b0;
      mem.wr_mem <= 1'b0;
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state           <= ACCESS;
            cnt             <= '0;
            wr_q            <= req_write;
            line_q          <= req_line_addr;
            mem.wr_mem      <= req_write;
            mem.rd_mem      <= !req_write;
            mem.addr_mem    <= {req_line_addr, {OFFW{1'b0}}};
            mem.mem_data_in <= req_wdata[DWIDTH-1:0];
          end
        end
        ACCESS: state <= GAP;
        GAP: begin
          if (mem.ready_mem) begin
            if (cnt == LAST) begin
              state      <= DONE;
              resp_valid <= 1'b1;
            end else begin
              state           <= ACCESS;
              cnt             <= cnt_nxt;
              mem.wr_mem      <= wr_q;
              mem.rd_mem      <= !wr_q;
              mem.addr_mem    <= {line_q, cnt_nxt};
              mem.mem_data_in <= nxt_word;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
